// File: rtl/sdc_ram_writer_pkg.sv
// Shared SD-card block-buffer definitions: state encoding,
// default RAM geometry and the word/block size helpers.
package sdc_ram_writer_pkg;

  localparam int RAM_WIDTH_DEF     = 64;
  localparam int RAM_ADDR_BITS_DEF = 8;
  localparam int BLK_BYTES_DEF     = 512;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  function automatic int bpw(input int w);
    return w / 8;
  endfunction

  function automatic int wpb(input int blk, input int w);
    return blk / (w / 8);
  endfunction

endpackage

// File: rtl/sdc_ram_writer_if.sv
// Command, byte-stream and RAM write-side bundle of the
// SD-card block writer.
interface sdc_ram_writer_if
  import sdc_ram_writer_pkg::*;
#(
  parameter int RAM_WIDTH     = RAM_WIDTH_DEF,
  parameter int RAM_ADDR_BITS = RAM_ADDR_BITS_DEF
) ();

  logic                     start;
  logic [RAM_ADDR_BITS-1:0] start_addr;
  logic                     abort;
  logic                     byte_vld;
  logic [7:0]               byte_in;
  logic                     wr_ram_enb;
  logic [RAM_ADDR_BITS-1:0] wr_ram_addr;
  logic [RAM_WIDTH-1:0]     wr_ram_data;
  logic                     busy;
  logic                     blk_done;
  logic                     ovf_err;

  modport master (
    output start, start_addr, abort, byte_vld, byte_in,
    input  wr_ram_enb, wr_ram_addr, wr_ram_data,
    input  busy, blk_done, ovf_err
  );

  modport slave (
    input  start, start_addr, abort, byte_vld, byte_in,
    output wr_ram_enb, wr_ram_addr, wr_ram_data,
    output busy, blk_done, ovf_err
  );

endinterface

// File: rtl/sdc_ram_writer.sv
// Packs SD-card read bytes little-endian into RAM words and
// writes one block per start command.
module sdc_ram_writer
  import sdc_ram_writer_pkg::*;
#(
  parameter int RAM_WIDTH     = RAM_WIDTH_DEF,
  parameter int RAM_ADDR_BITS = RAM_ADDR_BITS_DEF,
  parameter int BLK_BYTES     = BLK_BYTES_DEF
) (
  input logic clk,
  input logic reset,
  sdc_ram_writer_if.slave bus
);

  localparam int BPW = bpw(RAM_WIDTH);
  localparam int WPB = wpb(BLK_BYTES, RAM_WIDTH);
  localparam int IW  = (clog2(BPW) > 0) ? clog2(BPW) : 1;
  localparam int CW  = clog2(WPB + 1);
  localparam int A   = RAM_ADDR_BITS;
  localparam int W   = RAM_WIDTH;

  localparam logic [IW-1:0] LAST_IDX  = IW'(BPW - 1);
  localparam logic [CW-1:0] LAST_WORD = CW'(WPB - 1);

  state_t        state;
  state_t        state_nx;
  logic [IW-1:0] idx;
  logic [CW-1:0] cnt;
  logic [A-1:0]  addr;
  logic [W-9:0]  sh;
  logic          go;
  logic          take;
  logic          word_done;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next state: abort beats a word-completing byte.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (bus.start) state_nx = S_FILL;
      S_FILL: begin
        if (bus.abort)
          state_nx = S_IDLE;
        else if (word_done && cnt == LAST_WORD)
          state_nx = S_DONE;
      end
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Decoded strobes and state-derived status outputs.
  always_comb begin
    go           = (state == S_IDLE) && bus.start;
    take         = (state == S_FILL) && bus.byte_vld && !bus.abort;
    word_done    = take && (idx == LAST_IDX);
    bus.busy     = (state != S_IDLE);
    bus.blk_done = (state == S_DONE);
  end

  // Packing shift register: holds the first BPW-1 bytes of a word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     sh <= '0;
    else if (take) sh <= {bus.byte_in, sh[W-9:8]};
  end

  // Byte index, word counter and block address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx  <= '0;
      cnt  <= '0;
      addr <= '0;
    end else if (go) begin
      idx  <= '0;
      cnt  <= '0;
      addr <= bus.start_addr;
    end else if (take) begin
      idx <= word_done ? '0 : idx + IW'(1);
      if (word_done) begin
        cnt  <= cnt + CW'(1);
        addr <= addr + A'(1);
      end
    end
  end

  // Registered RAM write port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.wr_ram_enb  <= 1'b0;
      bus.wr_ram_addr <= '0;
      bus.wr_ram_data <= '0;
    end else begin
      bus.wr_ram_enb <= word_done;
      if (word_done) begin
        bus.wr_ram_addr <= addr;
        bus.wr_ram_data <= {bus.byte_in, sh};
      end
    end
  end

  // Sticky overflow: bytes outside FILL are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      bus.ovf_err <= 1'b0;
    else if (go)
      bus.ovf_err <= 1'b0;
    else if (bus.byte_vld && state != S_FILL)
      bus.ovf_err <= 1'b1;
  end

endmodule

// File: tb/tb_sdc_ram_writer.sv
// Bench for sdc_ram_writer: control table, directed block
// sequences and randomized blocks against a block-level model.
module tb_sdc_ram_writer;
  import sdc_ram_writer_pkg::*;

  localparam int W   = 64;
  localparam int A   = 8;
  localparam int BB  = 512;
  localparam int BPT = 8;
  localparam int WPT = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sdc_ram_writer_if #(.RAM_WIDTH(W), .RAM_ADDR_BITS(A)) bus ();

  sdc_ram_writer #(
    .RAM_WIDTH(W), .RAM_ADDR_BITS(A), .BLK_BYTES(BB)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [A-1:0] addr;
    logic [W-1:0] data;
    int           c;
  } wr_t;

  wr_t        got[$];
  int         done_n  = 0;
  int         done_c  = 0;
  int         rst_enb = 0;
  logic [7:0] blk[BB];
  int         bc[BB];

  always @(negedge clk) begin
    if (bus.wr_ram_enb) got.push_back('{bus.wr_ram_addr, bus.wr_ram_data, cyc});
    if (bus.blk_done) begin
      done_n++;
      done_c = cyc;
    end
    if (reset && bus.wr_ram_enb) rst_enb++;
  end

  typedef struct {
    string      nm;
    logic       start;
    logic       abort;
    logic       vld;
    logic [7:0] din;
    logic       busy;
    logic       done;
    logic       ovf;
    logic       enb;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", nm, a, e);
    end
  endtask

  function automatic logic [W-1:0] pack(input int w);
    logic [W-1:0] r;
    for (int k = 0; k < BPT; k++) r[8*k +: 8] = blk[w*BPT + k];
    return r;
  endfunction

  task automatic fill(input bit rnd);
    for (int i = 0; i < BB; i++) blk[i] = rnd ? 8'($urandom) : 8'(i);
  endtask

  task automatic begin_blk(input logic [7:0] sa);
    got.delete();
    done_n = 0;
    bus.start = 1'b1;
    bus.start_addr = sa;
    step();
    bus.start = 1'b0;
    chk("busy_rise", bus.busy, 1);
    chk("ovf_clr", bus.ovf_err, 0);
  endtask

  task automatic feed(input int n);
    for (int i = 0; i < n; i++) begin
      bus.byte_vld = 1'b1;
      bus.byte_in = blk[i];
      bc[i] = cyc;
      step();
    end
    bus.byte_vld = 1'b0;
  endtask

  task automatic run_block(input logic [7:0] sa, input int gap,
                           input int mid_start, input bit extra);
    logic [7:0] ea;
    int g;
    begin_blk(sa);
    for (int i = 0; i < BB; i++) begin
      g = (gap == 1) ? int'(i > 0) : (gap == 2) ? int'($urandom_range(0, 2)) : 0;
      for (int k = 0; k < g; k++) step();
      if (i == mid_start) begin
        bus.start = 1'b1;
        bus.start_addr = sa + 8'h55;
      end
      bus.byte_vld = 1'b1;
      bus.byte_in = blk[i];
      bc[i] = cyc;
      step();
      bus.byte_vld = 1'b0;
      bus.start = 1'b0;
    end
    chk("done_pulse", bus.blk_done, 1);
    chk("last_enb", bus.wr_ram_enb, 1);
    chk("ovf_clean", bus.ovf_err, 0);
    if (extra) begin
      bus.byte_vld = 1'b1;
      bus.byte_in = 8'hEE;
    end
    step();
    chk("busy_fall", bus.busy, 0);
    chk("done_once", bus.blk_done, 0);
    if (extra) begin
      step();
      step();
      bus.byte_vld = 1'b0;
      chk("ovf_set", bus.ovf_err, 1);
      step();
      step();
      chk("ovf_hold", bus.ovf_err, 1);
    end
    chk("n_writes", 64'(got.size()), 64'(WPT));
    chk("done_count", 64'(done_n), 1);
    chk("done_cycle", 64'(done_c), 64'(bc[BB-1] + 1));
    for (int w = 0; w < got.size() && w < WPT; w++) begin
      ea = sa + 8'(w);
      chk($sformatf("addr[%0d]", w), 64'(got[w].addr), 64'(ea));
      chk($sformatf("data[%0d]", w), got[w].data, pack(w));
      chk($sformatf("lat[%0d]", w), 64'(got[w].c), 64'(bc[w*BPT + BPT-1] + 1));
    end
  endtask

  vec_t tv[9];

  initial begin
    tv[0] = '{"idle",       0, 0, 0, 8'h00, 0, 0, 0, 0};
    tv[1] = '{"vld_idle",   0, 0, 1, 8'h11, 0, 0, 1, 0};
    tv[2] = '{"ovf_sticky", 0, 0, 0, 8'h00, 0, 0, 1, 0};
    tv[3] = '{"abort_idle", 0, 1, 0, 8'h00, 0, 0, 1, 0};
    tv[4] = '{"start",      1, 0, 0, 8'h00, 1, 0, 0, 0};
    tv[5] = '{"start_busy", 1, 0, 0, 8'h00, 1, 0, 0, 0};
    tv[6] = '{"vld_fill",   0, 0, 1, 8'hAB, 1, 0, 0, 0};
    tv[7] = '{"abort_fill", 0, 1, 0, 8'h00, 0, 0, 0, 0};
    tv[8] = '{"idle_after", 0, 0, 0, 8'h00, 0, 0, 0, 0};

    bus.start = 1'b0;
    bus.start_addr = '0;
    bus.abort = 1'b0;
    bus.byte_vld = 1'b0;
    bus.byte_in = '0;
    reset = 1'b1;
    step();
    step();
    chk("rst_enb", bus.wr_ram_enb, 0);
    chk("rst_addr", bus.wr_ram_addr, 0);
    chk("rst_data", bus.wr_ram_data, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.blk_done, 0);
    chk("rst_ovf", bus.ovf_err, 0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 9; i++) begin
      bus.start = tv[i].start;
      bus.abort = tv[i].abort;
      bus.byte_vld = tv[i].vld;
      bus.byte_in = tv[i].din;
      step();
      chk({tv[i].nm, "_busy"}, bus.busy, tv[i].busy);
      chk({tv[i].nm, "_done"}, bus.blk_done, tv[i].done);
      chk({tv[i].nm, "_ovf"}, bus.ovf_err, tv[i].ovf);
      chk({tv[i].nm, "_enb"}, bus.wr_ram_enb, tv[i].enb);
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.byte_vld = 1'b0;

    fill(0);
    run_block(8'h10, 0, -1, 0);
    chk("first_word", got[0].data, 64'h0706050403020100);
    run_block(8'h10, 1, -1, 0);
    run_block(8'hF0, 0, -1, 0);

    fill(1);
    begin_blk(8'h20);
    feed(13);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.blk_done, 0);
    step();
    step();
    chk("abort_writes", 64'(got.size()), 1);
    chk("abort_nodone", 64'(done_n), 0);
    if (got.size() > 0) begin
      chk("abort_addr", 64'(got[0].addr), 64'h20);
      chk("abort_data", got[0].data, pack(0));
    end
    run_block(8'h30, 2, -1, 0);

    begin_blk(8'h60);
    feed(BPT - 1);
    bus.byte_vld = 1'b1;
    bus.byte_in = blk[BPT-1];
    bus.abort = 1'b1;
    step();
    bus.byte_vld = 1'b0;
    bus.abort = 1'b0;
    chk("abort_tie_busy", bus.busy, 0);
    chk("abort_tie_enb", bus.wr_ram_enb, 0);
    step();
    chk("abort_tie_writes", 64'(got.size()), 0);

    begin_blk(8'h70);
    feed(BPT);
    chk("pend_enb", bus.wr_ram_enb, 1);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    step();
    chk("pend_writes", 64'(got.size()), 1);

    fill(1);
    run_block(8'h80, 0, 200, 1);
    fill(1);
    run_block(8'hA0, 2, -1, 0);

    fill(1);
    begin_blk(8'h40);
    feed(100);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_enb", bus.wr_ram_enb, 0);
    chk("mid_rst_addr", bus.wr_ram_addr, 0);
    chk("mid_rst_data", bus.wr_ram_data, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_done", bus.blk_done, 0);
    chk("mid_rst_ovf", bus.ovf_err, 0);
    step();
    step();
    reset = 1'b0;
    step();
    chk("mid_rst_strobe", 64'(rst_enb), 0);
    chk("mid_rst_idle", bus.busy, 0);
    chk("mid_rst_writes", 64'(got.size()), 12);
    chk("mid_rst_nodone", 64'(done_n), 0);

    for (int r = 0; r < 3; r++) begin
      fill(1);
      run_block(8'($urandom), 2, -1, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
